noc_gpio_responder: RTL

- Peripheral endpoint on the core-side NoC bus. It is the responder for read/write request packets sent by the core, and it sits alongside the memory interface as a second NoC target.
- Decodes single-beat request packets addressed to its node ID.
- Executes register accesses on a GPIO/interrupt register file.
- Returns a single-beat response packet on the outbound NoC lanes.
- Runs on the fabric clock.

---
 rtl/noc_gpio_responder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/noc_gpio_responder.sv
// NoC target exposing a GPIO/interrupt register file: single-beat requests in,
// single-beat responses out, one transaction every three cycles.

// Per-pin input synchroniser, rising-edge detector and sticky W1C status bit.
module noc_gpio_pin (
  input  logic fclk,
  input  logic rst,
  input  logic pin,
  input  logic clr,
  output logic sync,
  output logic stat
);
  logic meta, prev;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      stat <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
      // a new edge on the same cycle as a clear keeps the bit set
      stat <= (stat & ~clr) | (sync & ~prev);
    end
  end
endmodule

module noc_gpio_responder #(
  parameter int          GPIO_WIDTH = 32,
  parameter logic [3:0]  NODE_ID    = 4'h2,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  fclk,
  input  logic                  rst,
  input  logic [31:0][7:0]      noc_inp_dat,
  input  logic [5:0]            noc_inp_bp,
  input  logic                  noc_inp_bo,
  output logic [31:0][7:0]      noc_oup_dat,
  output logic [5:0]            noc_oup_bp,
  output logic                  noc_oup_bo,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0]  src;
    logic [7:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [5:0]  bp;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;
  req_t   fifo_mem [FIFO_DEPTH];
  req_t   req_in, cur_q;
  logic [AW:0] wr_ptr, rd_ptr;
  logic   empty, full, accept, push, pop, drop, exec;

  logic [GPIO_WIDTH-1:0] irq_en_q, irq_stat, irq_clr, gpio_sync;
  logic [31:0]           drop_cnt_q, rdata, rsp_data;
  logic                  is_rd, is_wr, short_req, hit, ro, ok, wr_en;
  logic [7:0]            status;
  logic [31:0][7:0]      rsp_beat;

  logic unused_bytes;
  assign unused_bytes = ^noc_inp_dat[31:8];

  // request capture and buffering
  assign accept = noc_inp_bo && (noc_inp_dat[0][3:0] == NODE_ID);
  assign req_in = '{src:   noc_inp_dat[0][7:4],
                    op:    noc_inp_dat[1],
                    addr:  {noc_inp_dat[3], noc_inp_dat[2]},
                    wdata: {noc_inp_dat[7], noc_inp_dat[6], noc_inp_dat[5], noc_inp_dat[4]},
                    bp:    noc_inp_bp};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = accept && (!full || pop);
  assign drop  = accept && full && !pop;

  always_ff @(posedge fclk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= req_in;
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cur_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur_q  <= fifo_mem[rd_ptr[AW-1:0]];
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  // control FSM
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        exec    = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // register decode for the request held in cur_q
  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    ro    = 1'b0;
    case (cur_q.addr)
      16'h0000: rdata[GPIO_WIDTH-1:0] = gpio_out;
      16'h0004: rdata[GPIO_WIDTH-1:0] = gpio_oe;
      16'h0008: begin rdata[GPIO_WIDTH-1:0] = gpio_sync; ro = 1'b1; end
      16'h000C: rdata[GPIO_WIDTH-1:0] = irq_en_q;
      16'h0010: rdata[GPIO_WIDTH-1:0] = irq_stat;
      16'h0014: begin rdata = drop_cnt_q; ro = 1'b1; end
      default:  hit = 1'b0;
    endcase
  end

  assign is_rd     = (cur_q.op == 8'h01);
  assign is_wr     = (cur_q.op == 8'h02);
  assign short_req = is_rd ? (cur_q.bp < 6'd4) : (cur_q.bp < 6'd8);
  assign ok        = (is_rd || is_wr) && !short_req && hit && !(is_wr && ro);
  assign wr_en     = exec && ok && is_wr;
  assign rsp_data  = (ok && is_rd) ? rdata : 32'h0;
  assign irq_clr   = (wr_en && cur_q.addr == 16'h0010) ? cur_q.wdata[GPIO_WIDTH-1:0] : '0;

  // a short beat is reported before its (possibly truncated) address is judged
  always_comb begin
    if (!(is_rd || is_wr)) status = 8'hFF;
    else if (short_req)    status = 8'hFE;
    else if (!ok)          status = 8'hFF;
    else                   status = cur_q.op | 8'h80;
  end

  always_comb begin
    rsp_beat    = '0;
    rsp_beat[0] = {NODE_ID, cur_q.src};
    rsp_beat[1] = status;
    rsp_beat[2] = cur_q.addr[7:0];
    rsp_beat[3] = cur_q.addr[15:8];
    {rsp_beat[7], rsp_beat[6], rsp_beat[5], rsp_beat[4]} = rsp_data;
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      gpio_out    <= '0;
      gpio_oe     <= '0;
      irq_en_q    <= '0;
      irq         <= 1'b0;
      noc_oup_dat <= '0;
      noc_oup_bp  <= '0;
      noc_oup_bo  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (cur_q.addr)
          16'h0000: gpio_out <= cur_q.wdata[GPIO_WIDTH-1:0];
          16'h0004: gpio_oe  <= cur_q.wdata[GPIO_WIDTH-1:0];
          16'h000C: irq_en_q <= cur_q.wdata[GPIO_WIDTH-1:0];
          default: ;
        endcase
      end
      irq        <= |(irq_stat & irq_en_q);
      noc_oup_bo <= exec;
      if (exec) begin
        noc_oup_dat <= rsp_beat;
        noc_oup_bp  <= 6'd8;
      end
    end
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    noc_gpio_pin u_pin (
      .fclk (fclk),
      .rst  (rst),
      .pin  (gpio_in[i]),
      .clr  (irq_clr[i]),
      .sync (gpio_sync[i]),
      .stat (irq_stat[i])
    );
  end
endmodule
